pi_request_queue: RTL and testbench

//  Pi-side front end feeding the 68000 bus-cycle engine. Synchronizes the Pi GPIO

---
 rtl/pi_request_queue.sv | 199 +++++++++++++++++++
 tb/tb_pi_request_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_request_queue.sv
`timescale 1ns/1ps
// pi_request_queue: Pi-side front end for the 68000 bus-cycle engine.
// Synchronizes the Pi write strobe, holds the Pi register file, queues committed
// bus requests in a small FIFO and issues them one at a time over valid/ready.
module pi_request_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] FW_VERSION = 16'h1040
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  pi_a,
  input  logic        pi_wr,
  input  logic        pi_rd,
  input  logic [15:0] pi_data_in,
  output logic [15:0] pi_data_out,
  output logic        pi_data_oe,
  output logic        pi_busy,
  input  logic [7:0]  bus_status,
  output logic [14:0] ctrl,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [23:0] req_addr,
  output logic [1:0]  req_size,
  output logic        req_read,
  output logic [2:0]  req_fc,
  output logic [31:0] req_wdata,
  input  logic        cpl_valid,
  input  logic [31:0] cpl_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  req_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_meta_q, wr_sync_q, wr_prev_q;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   addr_lo_q, addr_lo_d;
  logic [15:0]   last_hi_q, last_hi_d;
  logic [14:0]   ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          last_rd_q, last_rd_d;
  logic          inflight_q, inflight_d;
  logic          inflight_read_q, inflight_read_d;

  logic commit, push, push_ok, pop;
  req_t head, new_req;

  assign head      = fifo_q[rd_ptr_q];
  assign req_valid = (count_q != '0) && !inflight_q;
  assign pi_busy   = (count_q != '0) || inflight_q;
  assign pop       = req_valid && req_ready;
  assign ctrl      = ctrl_q;
  assign req_addr  = head.addr;
  assign req_size  = head.size;
  assign req_read  = head.read;
  assign req_fc    = head.fc;
  assign req_wdata = head.wdata;
  assign pi_data_oe = !pi_rd && pi_wr;

  // Strobe synchronizer plus edge history; idle level of the active-low strobe is 1.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_meta_q <= 1'b1;
      wr_sync_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_meta_q <= pi_wr;
      wr_sync_q <= wr_meta_q;
      wr_prev_q <= wr_sync_q;
    end
  end

  // Next-state logic for the register file, FIFO bookkeeping and in-flight tracking.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wdata_d         = wdata_q;
    addr_lo_d       = addr_lo_q;
    last_hi_d       = last_hi_q;
    ctrl_d          = ctrl_q;
    ovf_d           = ovf_q;
    rdata_d         = rdata_q;
    last_rd_d       = last_rd_q;
    inflight_d      = inflight_q;
    inflight_read_d = inflight_read_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;

    commit  = wr_prev_q && !wr_sync_q;
    push    = commit && (pi_a == 3'd3);
    push_ok = push && (count_q != FULL);
    new_req = '{addr:  {pi_data_in[7:0], addr_lo_q},
                size:  pi_data_in[9:8],
                read:  pi_data_in[10],
                fc:    pi_data_in[13:11],
                wdata: wdata_q};

    if (commit) begin
      unique case (pi_a)
        3'd0: wdata_d[15:0]  = pi_data_in;
        3'd1: wdata_d[31:16] = pi_data_in;
        3'd2: addr_lo_d      = pi_data_in;
        3'd3: last_hi_d      = {2'b00, pi_data_in[13:0]};
        3'd4: begin
          if (pi_data_in[15]) begin
            ctrl_d = ctrl_q | {1'b0, pi_data_in[13:0]};
          end else begin
            ctrl_d = ctrl_q & ~{1'b0, pi_data_in[13:0]};
            if (pi_data_in[14]) ovf_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A push into a full FIFO is dropped even if the head pops this same cycle.
    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      inflight_d      = 1'b1;
      inflight_read_d = head.read;
    end

    // Completions without a request in flight are ignored.
    if (cpl_valid && inflight_q) begin
      inflight_d = 1'b0;
      last_rd_d  = inflight_read_q;
      if (inflight_read_q) rdata_d = cpl_rdata;
    end

    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  // Control/status state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wdata_q         <= '0;
      addr_lo_q       <= '0;
      last_hi_q       <= '0;
      ctrl_q          <= '0;
      ovf_q           <= 1'b0;
      rdata_q         <= '0;
      last_rd_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_read_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      wdata_q         <= wdata_d;
      addr_lo_q       <= addr_lo_d;
      last_hi_q       <= last_hi_d;
      ctrl_q          <= ctrl_d;
      ovf_q           <= ovf_d;
      rdata_q         <= rdata_d;
      last_rd_q       <= last_rd_d;
      inflight_q      <= inflight_d;
      inflight_read_q <= inflight_read_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge sys_clk) begin
    // NOTE: storage is not reset; an entry is only visible once count says it was written.
    if (push_ok) fifo_q[wr_ptr_q] <= new_req;
  end

  // Pi read mux on the register select.
  always_comb begin
    pi_data_out = '0;
    unique case (pi_a)
      3'd0: pi_data_out = rdata_q[15:0];
      3'd1: pi_data_out = rdata_q[31:16];
      3'd2: pi_data_out = addr_lo_q;
      3'd3: pi_data_out = last_hi_q;
      3'd4: pi_data_out = {5'b0, ovf_q, pi_busy, last_rd_q, bus_status};
      3'd7: pi_data_out = FW_VERSION;
      default: pi_data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_pi_request_queue.sv
`timescale 1ns/1ps
// tb_pi_request_queue: directed scenarios plus a randomized register/bus-engine
// mix, checked against a transaction-level model of the Pi register file and queue.
module tb_pi_request_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] FW = 16'h1040;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  pi_a;
  logic        pi_wr, pi_rd;
  logic [15:0] pi_data_in, pi_data_out;
  logic        pi_data_oe, pi_busy;
  logic [7:0]  bus_status;
  logic [14:0] ctrl;
  logic        req_valid, req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic        req_read;
  logic [2:0]  req_fc;
  logic [31:0] req_wdata;
  logic        cpl_valid;
  logic [31:0] cpl_rdata;

  pi_request_queue #(.DEPTH(DEPTH), .FW_VERSION(FW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_a(pi_a), .pi_wr(pi_wr), .pi_rd(pi_rd),
    .pi_data_in(pi_data_in), .pi_data_out(pi_data_out), .pi_data_oe(pi_data_oe),
    .pi_busy(pi_busy), .bus_status(bus_status), .ctrl(ctrl), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size), .req_read(req_read),
    .req_fc(req_fc), .req_wdata(req_wdata), .cpl_valid(cpl_valid), .cpl_rdata(cpl_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  // Reference model state
  req_t        m_q[$];
  logic [31:0] m_wdata, m_rdata;
  logic [15:0] m_addr_lo, m_last_hi;
  logic [14:0] m_ctrl;
  logic        m_ovf, m_last_rd, m_inflight, m_inflight_read;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_wdata = '0; m_rdata = '0; m_addr_lo = '0; m_last_hi = '0; m_ctrl = '0;
    m_ovf = 1'b0; m_last_rd = 1'b0; m_inflight = 1'b0; m_inflight_read = 1'b0;
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
    req_t r;
    case (a)
      3'd0: m_wdata[15:0]  = d;
      3'd1: m_wdata[31:16] = d;
      3'd2: m_addr_lo      = d;
      3'd3: begin
        r.addr  = {d[7:0], m_addr_lo};
        r.size  = d[9:8];
        r.read  = d[10];
        r.fc    = d[13:11];
        r.wdata = m_wdata;
        m_last_hi = {2'b00, d[13:0]};
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(r);
      end
      3'd4: begin
        for (int b = 0; b < 14; b++)
          if (d[b]) m_ctrl[b] = d[15];
        if (!d[15] && d[14]) m_ovf = 1'b0;
      end
      default: ;
    endcase
  endfunction

  function automatic void m_complete(input logic [31:0] rd);
    if (m_inflight) begin
      if (m_inflight_read) m_rdata = rd;
      m_last_rd  = m_inflight_read;
      m_inflight = 1'b0;
    end
  endfunction

  function automatic logic [15:0] model_reg(input logic [2:0] a);
    logic busy;
    busy = (m_q.size() != 0) || m_inflight;
    case (a)
      3'd0: return m_rdata[15:0];
      3'd1: return m_rdata[31:16];
      3'd2: return m_addr_lo;
      3'd3: return m_last_hi;
      3'd4: return {5'b0, m_ovf, busy, m_last_rd, bus_status};
      3'd7: return FW;
      default: return 16'h0000;
    endcase
  endfunction

  // Pi write strobe; optionally pulses cpl_valid in the cycle the write commits.
  task automatic pi_write(input logic [2:0] a, input logic [15:0] d,
                          input bit with_cpl = 1'b0, input logic [31:0] rd = '0);
    @(posedge sys_clk); #1;
    pi_a = a; pi_data_in = d; pi_wr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge sys_clk); #1;
      if (k == 1) check("oe_off_during_wr", pi_data_oe, 1'b0);
      if (with_cpl) begin
        if (k == 1) check("busy_before_cpl", pi_busy, 1'b1);
        cpl_valid = (k == 2);
        cpl_rdata = rd;
        if (k == 3) check("cpl_push_valid_next", req_valid, 1'b1);
      end
    end
    pi_wr = 1'b1;
    repeat (3) @(posedge sys_clk);
    m_write(a, d);
    if (with_cpl) m_complete(rd);
  endtask

  task automatic pi_read_check(input logic [2:0] a, input string tag);
    @(negedge sys_clk);
    pi_a = a; pi_rd = 1'b0;
    #1;
    check(tag, pi_data_out, model_reg(a));
    check("oe_on_during_rd", pi_data_oe, 1'b1);
    pi_rd = 1'b1;
  endtask

  // Bus-engine side: accept the head request, optionally complete it after lat cycles.
  task automatic serve(input logic [31:0] rd, input int lat, input bit complete = 1'b1);
    int   t;
    req_t e;
    t = 0;
    @(negedge sys_clk);
    while (!req_valid && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    check("req_valid_wait", req_valid, 1'b1);
    if (!req_valid) return;
    check("model_has_entry", m_q.size() != 0, 1'b1);
    if (m_q.size() == 0) return;
    e = m_q.pop_front();
    check("req_addr", req_addr, e.addr);
    check("req_entry", {req_addr, req_size, req_read, req_fc, req_wdata}, e);
    req_ready = 1'b1;
    @(negedge sys_clk);
    req_ready = 1'b0;
    m_inflight = 1'b1;
    m_inflight_read = e.read;
    check("inflight_blocks_valid", req_valid, 1'b0);
    check("busy_inflight", pi_busy, 1'b1);
    if (complete) begin
      repeat (lat) @(negedge sys_clk);
      cpl_valid = 1'b1;
      cpl_rdata = rd;
      @(negedge sys_clk);
      cpl_valid = 1'b0;
      m_complete(rd);
      check("valid_after_cpl", req_valid, m_q.size() != 0);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; pi_a = '0; pi_wr = 1'b1; pi_rd = 1'b1; pi_data_in = '0;
    bus_status = 8'hA4; req_ready = 1'b0; cpl_valid = 1'b0; cpl_rdata = '0;
    m_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Reset state
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_busy", pi_busy, 1'b0);
    check("rst_ctrl", ctrl, 15'h0);
    pi_read_check(3'd0, "rst_reg0");
    pi_read_check(3'd4, "rst_status");

    // 1: long write request
    pi_write(3'd0, 16'h1234);
    pi_write(3'd1, 16'hABCD);
    pi_write(3'd2, 16'h0010);
    pi_write(3'd3, 16'h0300);
    @(negedge sys_clk);
    check("t1_valid", req_valid, 1'b1);
    check("t1_addr", req_addr, 24'h000010);
    check("t1_size", req_size, 2'b11);
    check("t1_read", req_read, 1'b0);
    check("t1_fc", req_fc, 3'd0);
    check("t1_wdata", req_wdata, 32'hABCD1234);
    check("t1_busy", pi_busy, 1'b1);
    serve(32'h0, 4);
    check("t1_busy_done", pi_busy, 1'b0);

    // 2: read request held until ready, then completion data captured
    pi_write(3'd3, 16'h0401);
    repeat (5) @(negedge sys_clk);
    check("t2_valid_held", req_valid, 1'b1);
    check("t2_addr", req_addr, 24'h010010);
    serve(32'hDEADBEEF, 3);
    @(negedge sys_clk);
    pi_a = 3'd0; #1; check("t2_reg0", pi_data_out, 16'hBEEF);
    pi_a = 3'd1; #1; check("t2_reg1", pi_data_out, 16'hDEAD);
    pi_a = 3'd4; #1; check("t2_status_rd", pi_data_out[8], 1'b1);
    check("t2_busy", pi_busy, 1'b0);
    pi_read_check(3'd3, "t2_reg3");

    // 3: overflow on the fifth commit, in-order drain, overflow clear
    for (int i = 0; i < 5; i++) pi_write(3'd3, 16'h0300 | 16'(i + 1));
    @(negedge sys_clk);
    pi_a = 3'd4; #1; check("t3_overflow", pi_data_out[10], 1'b1);
    pi_read_check(3'd4, "t3_status");
    for (int i = 0; i < DEPTH; i++) serve(32'h0, 1);
    check("t3_drained", req_valid, 1'b0);
    pi_write(3'd4, 16'h4000);
    @(negedge sys_clk);
    pi_a = 3'd4; #1; check("t3_overflow_clr", pi_data_out[10], 1'b0);

    // 4: control set/clear and firmware version
    pi_write(3'd4, 16'h8005);
    check("t4_ctrl_set", ctrl, 15'h0005);
    pi_write(3'd4, 16'h0001);
    check("t4_ctrl_clr", ctrl, 15'h0004);
    @(negedge sys_clk);
    pi_a = 3'd7; #1; check("t4_fw", pi_data_out, 16'h1040);

    // 5: completion in the same cycle as an ADDR_HI commit
    pi_write(3'd2, 16'h2222);
    pi_write(3'd3, 16'h0455);
    serve(32'h0, 0, 1'b0);
    pi_write(3'd3, 16'h0156, 1'b1, 32'h600DF00D);
    pi_read_check(3'd0, "t5_reg0");
    serve(32'h0, 2);

    // Randomized register traffic and bus-engine service
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [2:0] a;
      op = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      if (op <= 4) begin
        if (op <= 1) a = 3'd3;
        pi_write(a, 16'($urandom));
      end else if (op <= 6 && m_q.size() != 0) begin
        serve($urandom, $urandom_range(0, 5));
      end else begin
        bus_status = 8'($urandom);
        pi_read_check(a, "rnd_reg");
        check("rnd_ctrl", ctrl, m_ctrl);
        check("rnd_valid", req_valid, m_q.size() != 0);
      end
    end
    while (m_q.size() != 0) serve($urandom, 1);

    // 6: reset with two queued and one in flight
    pi_write(3'd4, 16'h8003);
    for (int i = 0; i < 3; i++) pi_write(3'd3, 16'h0300 | 16'(i));
    serve(32'h0, 0, 1'b0);
    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    #1;
    check("t6_valid", req_valid, 1'b0);
    check("t6_busy", pi_busy, 1'b0);
    check("t6_ctrl", ctrl, 15'h0);
    m_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    cpl_valid = 1'b1; cpl_rdata = 32'h12345678;
    @(negedge sys_clk);
    cpl_valid = 1'b0;
    m_complete(32'h12345678);
    pi_read_check(3'd0, "t6_reg0");
    pi_read_check(3'd4, "t6_status");
    check("t6_busy_after", pi_busy, 1'b0);
    check("t6_valid_after", req_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
